iccm_prog_ctrl: RTL and testbench
=================================

// Module: iccm_prog_ctrl
// PURPOSE
//  Boot-time loader for the 4 KiW instruction memory. Takes a byte stream from the boot UART,
//  assembles little-endian 32-bit words and drives the ICCM programming port with one write per word.
//  Holds the core in reset (prog_rst_no=0) until the end-of-image word arrives, then releases it,
//  handing the memory back to the TL-UL path.
// PARAMETERS
//  AW          12            word-address width of the instruction memory
//  DW          32            data width; fixed at 4 bytes/word
//  END_WORD    32'h0000_0FFF end-of-image marker word; never written to memory
//  TIMEOUT_CYC 100000        idle cycles before a partial word is discarded (must be >= 2)
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   synchronous reset, active-high
//  rx_byte_i    in   8   received byte
//  rx_valid_i   in   1   1-cycle strobe: rx_byte_i valid
//  restart_i    in   1   1-cycle strobe: re-enter loading from address 0
//  we_o         out  1   ICCM write strobe (feeds iccm_ctrl_we)
//  addr_o       out  AW  ICCM word address (feeds iccm_ctrl_addr)
//  wdata_o      out  DW  ICCM write data (feeds iccm_ctrl_wdata)
//  prog_rst_no  out  1   0 = core held in reset / ICCM owned by loader; 1 = released
//  done_o       out  1   image loaded (level)
//  ovf_o        out  1   image overflowed memory (sticky until reset/restart)
//  tmo_o        out  1   1-cycle pulse: partial word discarded on timeout
//  cksum_err_o  out  1   checksum mismatch (sticky); tied 0 without ICCM_PROG_CKSUM_EN
// BEHAVIOUR
//  - Reset and restart_i: state=LOAD, byte_cnt=0, word_addr=0, idle_cnt=0, all outputs 0.
//    This includes prog_rst_no=0. A partial word in progress is dropped.
//  - Byte assembly (LOAD only): the byte with byte_cnt=k goes to word[8k+7:8k]; byte_cnt wraps 3->0.
//  - Accepting the 4th byte at cycle N: if word==END_WORD -> no write, go to DONE (or CKSUM).
//    Otherwise, at cycle N+1: we_o=1 for exactly one cycle, addr_o=word_addr, wdata_o=word.
//    word_addr then increments. A byte arriving at N+1 is accepted normally (no back-pressure).
//  - Overflow: a write to addr 0xFFF is performed. The next completed non-END word is not written.
//    ovf_o=1 and the state goes to DONE.
//  - Timeout: idle_cnt counts cycles with byte_cnt!=0 and no rx_valid_i; it clears on any byte.
//    When it reaches TIMEOUT_CYC-1: byte_cnt=0 and tmo_o pulses; word_addr is unchanged.
//  - States: LOAD -> DONE on END_WORD or overflow; LOAD -> CKSUM on END_WORD (macro defined).
//    CKSUM -> DONE on match; CKSUM -> ERR on mismatch. Any state -> LOAD on restart_i.
//  - DONE: prog_rst_no=1 and done_o=1, both registered (asserted the cycle after entry); rx ignored.
//  - ERR: prog_rst_no=0, cksum_err_o=1, rx ignored.
//  - restart_i together with rx_valid_i in the same cycle: restart wins and the byte is dropped.
//  - addr_o/wdata_o hold their last values when we_o=0.
// CONFIGURATION
//  ICCM_PROG_CKSUM_EN defined: a running XOR of every written word is kept.
//    After END_WORD, the next 4 bytes form a checksum word, compared against the XOR (CKSUM state).
//    Timeout in CKSUM also discards partial bytes.
//  ICCM_PROG_CKSUM_EN undefined: no CKSUM/ERR state and no XOR register; cksum_err_o=0.
// STRUCTURE
//  iccm_prog_pkg: state enum (LOAD, CKSUM, DONE, ERR) and the default END_WORD constant.
//  Sub-module iccm_word_assembler: byte_cnt, shift register, idle/timeout counter.
//    Outputs word_valid/word/tmo.
//  Top level: FSM, address counter, output registers, optional checksum.
// TESTING
//  1 Reset, send 11 22 33 44 -> we_o once, addr_o=0, wdata_o=0x44332211; prog_rst_no=0.
//  2 Send 3 words then FF 0F 00 00 -> 3 writes at addr 0,1,2; no 4th write.
//    done_o=1 and prog_rst_no=1 the cycle after the END byte completes.
//  3 Send 2 bytes, idle TIMEOUT_CYC cycles, send AA BB CC DD -> tmo_o pulse.
//    Then a write at addr 0 with 0xDDCCBBAA.
//  4 Send 4097 non-END words -> 4096 writes (last at 0xFFF); ovf_o=1, done_o=1.
//  5 In DONE, assert restart_i with rx_valid_i -> byte dropped.
//    prog_rst_no=0, the next word is written at addr 0.
//  6 (CKSUM_EN) Words 0x1, 0x2, END, checksum 0x3 -> DONE; a repeat with checksum 0x4 -> cksum_err_o=1.
//    prog_rst_no stays 0.

Source files
------------

// File: rtl/iccm_prog_pkg.sv
// Shared constants for the ICCM boot loader: FSM state codes and the
// default end-of-image marker. Optional checksum build: ICCM_PROG_CKSUM_EN.
package iccm_prog_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_CKSUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_ERR   = 2'd3;

    localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;

endpackage

// File: rtl/iccm_prog_ctrl_if.sv
// ICCM programming port: one write strobe with word address and data.
// The loader drives it through the master modport, the memory side samples
// it through the slave modport.
interface iccm_prog_ctrl_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/iccm_word_assembler.sv
// Packs the boot UART byte stream into little-endian words and discards a
// partial word after TIMEOUT_CYC idle cycles.
module iccm_word_assembler #(
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic          word_valid_o,
    output logic [DW-1:0] word_o,
    output logic          tmo_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [1:0]    byte_cnt;
    logic [CW-1:0] idle_cnt;
    logic [DW-9:0] shreg;
    logic          accept;

    assign accept       = en_i & rx_valid_i;
    assign word_valid_o = accept & (&byte_cnt);
    assign word_o       = {rx_byte_i, shreg};

    // Byte position and idle counter; a stalled partial word is dropped on timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            byte_cnt <= '0;
            idle_cnt <= '0;
            tmo_o    <= 1'b0;
        end else begin
            tmo_o <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
                idle_cnt <= '0;
            end else if (byte_cnt != 2'd0) begin
                if (idle_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                    tmo_o    <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // Lower three bytes are stored; the fourth is merged combinationally into word_o.
    always_ff @(posedge clk_i) begin
        if (accept && !(&byte_cnt)) begin
            shreg[int'(byte_cnt)*8 +: 8] <= rx_byte_i;
        end
    end

endmodule

// File: rtl/iccm_prog_ctrl.sv
// Boot-time ICCM loader: writes assembled words to consecutive addresses,
// holds the core in reset until the end-of-image word, flags overflow.
// Optional feature macro ICCM_PROG_CKSUM_EN adds an XOR checksum check.
module iccm_prog_ctrl
    import iccm_prog_pkg::*;
#(
    parameter int          AW          = 12,
    parameter int          DW          = 32,
    parameter logic [31:0] END_WORD    = END_WORD_DEF,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    input  logic              restart_i,
    iccm_prog_ctrl_if.master  iccm,
    output logic              prog_rst_no,
    output logic              done_o,
    output logic              ovf_o,
    output logic              tmo_o,
    output logic              cksum_err_o
);

    state_t        state;
    logic [AW-1:0] word_addr;
    logic          full;
    logic          word_valid;
    logic [DW-1:0] word;
    logic          asm_en;

    // Bytes are only consumed while an image (or its checksum) is expected.
    assign asm_en = (state == ST_LOAD) || (state == ST_CKSUM);

    iccm_word_assembler #(
        .DW          (DW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (restart_i),
        .en_i         (asm_en),
        .rx_byte_i    (rx_byte_i),
        .rx_valid_i   (rx_valid_i),
        .word_valid_o (word_valid),
        .word_o       (word),
        .tmo_o        (tmo_o)
    );

`ifdef ICCM_PROG_CKSUM_EN
    logic [DW-1:0] xor_acc;

    // Running XOR over every word actually written to the ICCM.
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            xor_acc <= '0;
        end else if (state == ST_LOAD && word_valid && word != END_WORD && !full) begin
            xor_acc <= xor_acc ^ word;
        end
    end
`else
    assign cksum_err_o = 1'b0;
`endif

    // Loader FSM, address counter and registered ICCM/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            state       <= ST_LOAD;
            word_addr   <= '0;
            full        <= 1'b0;
            iccm.we     <= 1'b0;
            iccm.addr   <= '0;
            iccm.wdata  <= '0;
            prog_rst_no <= 1'b0;
            done_o      <= 1'b0;
            ovf_o       <= 1'b0;
`ifdef ICCM_PROG_CKSUM_EN
            cksum_err_o <= 1'b0;
`endif
        end else begin
            iccm.we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (word_valid) begin
                        if (word == END_WORD) begin
`ifdef ICCM_PROG_CKSUM_EN
                            state       <= ST_CKSUM;
`else
                            state       <= ST_DONE;
                            done_o      <= 1'b1;
                            prog_rst_no <= 1'b1;
`endif
                        end else if (full) begin
                            state       <= ST_DONE;
                            ovf_o       <= 1'b1;
                            done_o      <= 1'b1;
                            prog_rst_no <= 1'b1;
                        end else begin
                            iccm.we    <= 1'b1;
                            iccm.addr  <= word_addr;
                            iccm.wdata <= word;
                            word_addr  <= word_addr + 1'b1;
                            if (&word_addr) begin
                                full <= 1'b1;
                            end
                        end
                    end
                end
`ifdef ICCM_PROG_CKSUM_EN
                ST_CKSUM: begin
                    if (word_valid) begin
                        if (word == xor_acc) begin
                            state       <= ST_DONE;
                            done_o      <= 1'b1;
                            prog_rst_no <= 1'b1;
                        end else begin
                            state       <= ST_ERR;
                            cksum_err_o <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iccm_prog_ctrl.sv
// Self-checking bench for iccm_prog_ctrl: directed scenarios plus random
// byte traffic, compared every cycle against a byte-queue reference model.
// Honours ICCM_PROG_CKSUM_EN when defined.
module tb_iccm_prog_ctrl;

    localparam int          AW    = 12;
    localparam int          DW    = 32;
    localparam int          TMO   = 16;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] ENDW  = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          restart;
    logic          prog_rst_no, done, ovf, tmo, cerr;

    iccm_prog_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    iccm_prog_ctrl #(
        .AW (AW), .DW (DW), .END_WORD (ENDW), .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_byte_i   (rx_byte),
        .rx_valid_i  (rx_valid),
        .restart_i   (restart),
        .iccm        (bus),
        .prog_rst_no (prog_rst_no),
        .done_o      (done),
        .ovf_o       (ovf),
        .tmo_o       (tmo),
        .cksum_err_o (cerr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 loading image, 1 awaiting checksum, 2 finished, 3 checksum error
    bit          started = 0;
    logic [7:0]  m_q[$];
    int          m_idle, m_writes, m_phase;
    logic [31:0] m_xor;
    logic        e_we, e_prn, e_done, e_ovf, e_tmo, e_cerr;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;

    function automatic void model_reset();
        m_q.delete();
        m_idle = 0; m_writes = 0; m_phase = 0; m_xor = '0;
        e_we = 0; e_addr = '0; e_wdata = '0;
        e_prn = 0; e_done = 0; e_ovf = 0; e_tmo = 0; e_cerr = 0;
    endfunction

    function automatic void finish_ok();
        m_phase = 2; e_done = 1; e_prn = 1;
    endfunction

    function automatic void take_word(input logic [31:0] w);
        if (m_phase == 0) begin
            if (w == ENDW) begin
`ifdef ICCM_PROG_CKSUM_EN
                m_phase = 1;
`else
                finish_ok();
`endif
            end else if (m_writes == DEPTH) begin
                e_ovf = 1;
                finish_ok();
            end else begin
                e_we = 1; e_addr = 12'(m_writes); e_wdata = w;
                m_writes++;
                m_xor ^= w;
            end
        end else begin
            if (w == m_xor) finish_ok();
            else begin m_phase = 3; e_cerr = 1; end
        end
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (rst || restart) begin
            model_reset();
        end else begin
            e_we = 0; e_tmo = 0;
            if (m_phase < 2) begin
                if (rx_valid) begin
                    m_idle = 0;
                    m_q.push_back(rx_byte);
                    if (m_q.size() == 4) begin
                        logic [31:0] w;
                        w = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_q.delete();
                        take_word(w);
                    end
                end else if (m_q.size() > 0) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_q.delete();
                        m_idle = 0;
                        e_tmo = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [43:0] log_q[$];
    int          tmo_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            check("outputs", {14'd0, bus.we, bus.addr, bus.wdata, prog_rst_no, done, ovf, tmo, cerr},
                  {14'd0, e_we, e_addr, e_wdata, e_prn, e_done, e_ovf, e_tmo, e_cerr});
            if (bus.we) log_q.push_back({bus.addr, bus.wdata});
            if (tmo) tmo_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap > 0 && i < 3) idle($urandom_range(0, gap));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(2); rst = 1'b0;
        log_q.delete();
        tmo_cnt = 0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ENDW) w = w ^ 32'h1;
        return w;
    endfunction

    logic [31:0] wsave[3];
    logic [31:0] wlast;

    initial begin
        rst = 1'b1; rx_valid = 1'b0; restart = 1'b0; rx_byte = 8'h00;
        idle(3);
        rst = 1'b0;
        check("rst_prog_rst_no", prog_rst_no, 0);
        check("rst_done", done, 0);
        check("rst_we", bus.we, 0);

        // Test 1: one word
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t1_we_pulse", bus.we, 1);
        idle(2);
        check("t1_nwrites", log_q.size(), 1);
        check("t1_write", log_q[0], {12'h000, 32'h4433_2211});
        check("t1_prog_rst_no", prog_rst_no, 0);

        // Test 2: three words then end-of-image
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wsave[i] = rand_word();
            send_word(wsave[i], 3);
        end
        send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h00); send_byte(8'h00);
        check("t2_done_next_cycle", done, 1);
        check("t2_prn_next_cycle", prog_rst_no, 1);
        idle(2);
        check("t2_nwrites", log_q.size(), 3);
        check("t2_model_writes", m_writes, 3);
        for (int i = 0; i < 3; i++) check("t2_write", log_q[i], {12'(i), wsave[i]});

        // Test 3: timeout discards a partial word
        do_reset();
        send_byte(8'h01); send_byte(8'h02);
        idle(TMO + 1);
        check("t3_tmo_pulses", tmo_cnt, 1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(2);
        check("t3_nwrites", log_q.size(), 1);
        check("t3_write", log_q[0], {12'h000, 32'hDDCC_BBAA});

        // Test 4: overflow
        do_reset();
        wlast = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] w;
            w = rand_word();
            if (i == DEPTH - 1) wlast = w;
            send_word(w, 0);
        end
        idle(2);
        check("t4_nwrites", log_q.size(), DEPTH);
        check("t4_last_write", log_q[DEPTH-1], {12'hFFF, wlast});
        check("t4_ovf", ovf, 1);
        check("t4_done", done, 1);

        // Test 5: restart with a simultaneous byte drops that byte
        rx_byte = 8'h55; rx_valid = 1'b1; restart = 1'b1;
        tick();
        rx_valid = 1'b0; restart = 1'b0;
        check("t5_prn", prog_rst_no, 0);
        check("t5_ovf_cleared", ovf, 0);
        log_q.delete();
        send_word(32'h1234_5678, 2);
        idle(2);
        check("t5_write", log_q[0], {12'h000, 32'h1234_5678});

`ifdef ICCM_PROG_CKSUM_EN
        // Test 6: checksum good then bad
        do_reset();
        send_word(32'h1, 0); send_word(32'h2, 0); send_word(ENDW, 0); send_word(32'h3, 0);
        idle(1);
        check("t6_done", done, 1);
        check("t6_cerr_clear", cerr, 0);
        restart = 1'b1; tick(); restart = 1'b0;
        send_word(32'h1, 0); send_word(32'h2, 0); send_word(ENDW, 0); send_word(32'h4, 0);
        idle(1);
        check("t6_cerr", cerr, 1);
        check("t6_prn", prog_rst_no, 0);
`endif

        // Random traffic
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (done && $urandom_range(0, 9) == 0) r = 0;
            if (r < 2) begin
                rx_valid = $urandom_range(0, 1) == 1;
                rx_byte  = 8'($urandom);
                restart  = 1'b1;
                tick();
                restart = 1'b0; rx_valid = 1'b0;
            end else if (r < 5) begin
                send_word(ENDW, 2);
            end else if (r < 8) begin
                idle(TMO - 2 + $urandom_range(0, 4));
            end else begin
                send_byte(8'($urandom));
                idle($urandom_range(0, 2));
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
